ddr4_cmd_responder: RTL

DDR4_CMD_RESPONDER -- requirements
Module: ddr4_cmd_responder

---
 rtl/ddr4_cmd_responder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr4_cmd_responder.sv
// DDR4 command decoder with per-bank open tracking, protocol checks and
// read/write DQ window timing driven from a latency shift pipeline.
module ddr4_cmd_responder #(
  parameter int AL_CYC  = 0,
  parameter int CL_CYC  = 11,
  parameter int CWL_CYC = 9
) (
  input  logic        CK_t,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        act_n,
  input  logic        RAS_n_A16,
  input  logic        CAS_n_A15,
  input  logic        WE_n_A14,
  input  logic        A17,
  input  logic        A13,
  input  logic        A12_BC_n,
  input  logic        A11,
  input  logic        A10_AP,
  input  logic [1:0]  bg_addr,
  input  logic [1:0]  ba_addr,
  input  logic [9:0]  A9_A0,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic [3:0]  cmd_bank,
  output logic [17:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic [15:0] bank_open,
  output logic        rd_dq_en,
  output logic        wr_dq_en,
  output logic        proto_err,
  output logic [2:0]  err_code
);

  localparam int RL    = AL_CYC + CL_CYC;
  localparam int WL    = AL_CYC + CWL_CYC;
  localparam int DEPTH = 48;

  typedef enum logic [3:0] {
    C_ACT  = 4'd0,
    C_RD   = 4'd1,
    C_RDA  = 4'd2,
    C_WR   = 4'd3,
    C_WRA  = 4'd4,
    C_PRE  = 4'd5,
    C_PREA = 4'd6,
    C_REF  = 4'd7,
    C_MRS  = 4'd8,
    C_ZQC  = 4'd9,
    C_RFU  = 4'd15
  } cmd_e;

  logic             dec_v;
  cmd_e             dec_code;
  logic [3:0]       bnk;
  logic [17:0]      row;
  logic             is_rd;
  logic             is_wr;
  logic [2:0]       err;
  logic             ok;
  logic [2:0]       gap;
  logic [2:0]       gap_nx;
  logic [15:0]      open_nx;

  logic [DEPTH-1:0]      rd_sr, rd_nx;
  logic [DEPTH-1:0]      wr_sr, wr_nx;
  logic [DEPTH-1:0]      rap_v, rap_v_nx;
  logic [DEPTH-1:0]      wap_v, wap_v_nx;
  logic [DEPTH-1:0][3:0] rap_b, rap_b_nx;
  logic [DEPTH-1:0][3:0] wap_b, wap_b_nx;

  assign bnk = {bg_addr, ba_addr};
  assign row = {A17, RAS_n_A16, CAS_n_A15, WE_n_A14,
                A13, A12_BC_n, A11, A10_AP, A9_A0};

  always_comb begin
    dec_v    = 1'b0;
    dec_code = C_RFU;
    if (!cs_n) begin
      dec_v = 1'b1;
      if (!act_n) begin
        dec_code = C_ACT;
      end else begin
        unique case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
          3'b000: dec_code = C_MRS;
          3'b001: dec_code = C_REF;
          3'b010: dec_code = A10_AP ? C_PREA : C_PRE;
          3'b011: dec_code = C_RFU;
          3'b100: dec_code = A10_AP ? C_WRA : C_WR;
          3'b101: dec_code = A10_AP ? C_RDA : C_RD;
          3'b110: dec_code = C_ZQC;
          3'b111: dec_v    = 1'b0;
        endcase
      end
    end
  end

  assign is_rd = dec_code inside {C_RD, C_RDA};
  assign is_wr = dec_code inside {C_WR, C_WRA};

  // Checks use the registered bank state, before any same-cycle auto-close.
  always_comb begin
    err = 3'd0;
    if (dec_v) begin
      case (dec_code)
        C_ACT:
          if (bank_open[bnk]) err = 3'd1;
        C_RD, C_RDA, C_WR, C_WRA:
          if (!bank_open[bnk])    err = 3'd2;
          else if (gap < 3'd4)    err = 3'd5;
        C_REF, C_MRS, C_ZQC:
          if (|bank_open) err = 3'd3;
        C_RFU:
          err = 3'd4;
        default: ;
      endcase
    end
  end

  assign ok = dec_v && (err == 3'd0);

  always_comb begin
    gap_nx = (gap == 3'd4) ? 3'd4 : gap + 3'd1;
    if (ok && (is_rd || is_wr)) gap_nx = 3'd1;
  end

  // A burst at index RL-1 reaches bit 0 exactly RL edges later.
  always_comb begin
    rd_nx    = rd_sr >> 1;
    wr_nx    = wr_sr >> 1;
    rap_v_nx = rap_v >> 1;
    wap_v_nx = wap_v >> 1;
    rap_b_nx = rap_b >> 4;
    wap_b_nx = wap_b >> 4;
    if (ok && is_rd) begin
      rd_nx[RL+2 -: 4] = 4'hF;
      if (dec_code == C_RDA) begin
        rap_v_nx[RL+3] = 1'b1;
        rap_b_nx[RL+3] = bnk;
      end
    end
    if (ok && is_wr) begin
      wr_nx[WL+2 -: 4] = 4'hF;
      if (dec_code == C_WRA) begin
        wap_v_nx[WL+3] = 1'b1;
        wap_b_nx[WL+3] = bnk;
      end
    end
  end

  always_comb begin
    open_nx = bank_open;
    if (rap_v[0]) open_nx[rap_b[0]] = 1'b0;
    if (wap_v[0]) open_nx[wap_b[0]] = 1'b0;
    if (ok) begin
      case (dec_code)
        C_ACT:   open_nx[bnk] = 1'b1;
        C_PRE:   open_nx[bnk] = 1'b0;
        C_PREA:  open_nx      = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      bank_open <= '0;
      rd_dq_en  <= 1'b0;
      wr_dq_en  <= 1'b0;
      proto_err <= 1'b0;
      err_code  <= '0;
      gap       <= 3'd4;
      rd_sr     <= '0;
      wr_sr     <= '0;
      rap_v     <= '0;
      wap_v     <= '0;
      rap_b     <= '0;
      wap_b     <= '0;
    end else begin
      cmd_valid <= dec_v;
      proto_err <= (err != 3'd0);
      if (dec_v) begin
        cmd_code <= dec_code;
        cmd_bank <= bnk;
        cmd_row  <= row;
        cmd_col  <= A9_A0;
      end
      if (err != 3'd0) err_code <= err;
      bank_open <= open_nx;
      rd_dq_en  <= rd_sr[0];
      wr_dq_en  <= wr_sr[0];
      gap       <= gap_nx;
      rd_sr     <= rd_nx;
      wr_sr     <= wr_nx;
      rap_v     <= rap_v_nx;
      wap_v     <= wap_v_nx;
      rap_b     <= rap_b_nx;
      wap_b     <= wap_b_nx;
    end
  end

endmodule
